// File: rtl/nios_mul_pkg.sv
// Shared definitions for the Nios II sequential multiplier: op encodings,
// sequencer state encoding and the partial-product issue table.
package nios_mul_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int ACC_W  = 64;

  // Multiply flavours carried on req_op
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } mul_op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // One row of the issue table: which operand halves feed the cell and how
  // far the returning product is shifted (in units of HALF_W bits).
  typedef struct packed {
    logic       a_hi;
    logic       b_hi;
    logic [1:0] shift;
  } pp_sel_t;

  // Issue order: lo*lo, lo*hi, hi*lo, hi*hi. The hi*hi term comes last so a
  // plain MUL can stop after three issues; it only affects bits above 63..32
  // of the low word.
  function automatic pp_sel_t pp_sel(input logic [1:0] idx);
    pp_sel_t sel;
    sel.a_hi  = 1'b0;
    sel.b_hi  = 1'b0;
    sel.shift = 2'd0;
    case (idx)
      2'd0: begin sel.a_hi = 1'b0; sel.b_hi = 1'b0; sel.shift = 2'd0; end
      2'd1: begin sel.a_hi = 1'b0; sel.b_hi = 1'b1; sel.shift = 2'd1; end
      2'd2: begin sel.a_hi = 1'b1; sel.b_hi = 1'b0; sel.shift = 2'd1; end
      default: begin sel.a_hi = 1'b1; sel.b_hi = 1'b1; sel.shift = 2'd2; end
    endcase
    return sel;
  endfunction

  // Index of the final partial product for an op
  function automatic logic [1:0] pp_last(input mul_op_e op);
    return (op == OP_MUL) ? 2'd2 : 2'd3;
  endfunction

  // Select the upper or lower half of a 32-bit operand
  function automatic logic [HALF_W-1:0] pick_half(input logic [WORD_W-1:0] word,
                                                  input logic hi);
    return hi ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/nios_mul_tag_pipe.sv
// Delay line that tracks which in-flight multiplier-cell products belong to
// the current request and where each one lands in the accumulator. It moves
// in lock-step with the cell, so it only advances when the cell is enabled.
module nios_mul_tag_pipe
  import nios_mul_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  input  logic       in_valid,
  input  logic [1:0] in_shift,
  output logic       out_valid,
  output logic [1:0] out_shift,
  output logic       busy
);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0][1:0] shift_q, shift_d;

  // Shift a new tag in at stage 0 whenever the cell pipeline advances
  always_comb begin
    valid_d = valid_q;
    shift_d = shift_q;
    if (adv) begin
      valid_d[0] = in_valid;
      shift_d[0] = in_shift;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        shift_d[i] = shift_q[i-1];
      end
    end
  end

  // Tag storage; cleared asynchronously so stale products are never claimed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      shift_q <= '0;
    end else begin
      valid_q <= valid_d;
      shift_q <= shift_d;
    end
  end

  // Busy means more tags are queued behind the one currently leaving
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      busy = busy | valid_q[i];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_shift = shift_q[DEPTH-1];

endmodule

// File: rtl/nios_system_nios2_gen2_0_cpu_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer driving a shared 16x16 unsigned
// multiplier cell. Partial products are accumulated unsigned into a 64-bit
// register and the signed variants are fixed up once at the end.
module nios_system_nios2_gen2_0_cpu_mul_seq
  import nios_mul_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [WORD_W-1:0]   req_src1,
  input  logic [WORD_W-1:0]   req_src2,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_W-1:0]   rsp_result,
  output logic [HALF_W-1:0]   mc_a,
  output logic [HALF_W-1:0]   mc_b,
  output logic                mc_en,
  input  logic [WORD_W-1:0]   mc_p
);

  seq_state_e          state_q, state_d;
  mul_op_e             op_q, op_d;
  logic [WORD_W-1:0]   src1_q, src1_d;
  logic [WORD_W-1:0]   src2_q, src2_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [HALF_W-1:0]   mc_a_q, mc_a_d;
  logic [HALF_W-1:0]   mc_b_q, mc_b_d;
  logic [WORD_W-1:0]   result_q, result_d;

  logic                accept;
  logic                issue_push;
  logic                last_issue;
  logic                tag_out_valid;
  logic [1:0]          tag_out_shift;
  logic                tag_busy;
  pp_sel_t             first_sel;
  pp_sel_t             cur_sel;
  pp_sel_t             next_sel;
  logic [ACC_W-1:0]    pp_term;
  logic [WORD_W-1:0]   corr_a;
  logic [WORD_W-1:0]   corr_b;
  logic [WORD_W-1:0]   fixed_hi;

  assign accept     = req_valid && req_ready;
  assign last_issue = (cnt_q == pp_last(op_q));
  assign first_sel  = pp_sel(2'd0);
  assign cur_sel    = pp_sel(cnt_q);
  assign next_sel   = pp_sel(cnt_q + 2'd1);

  // Returning product placed at its weight; wraps naturally at 64 bits
  assign pp_term = {{(ACC_W-WORD_W){1'b0}}, mc_p} << {tag_out_shift, 4'b0000};

  // Signed correction terms: a negative operand was treated as 2^32 larger,
  // which added the other operand into the high word once too often.
  assign corr_a   = (src1_q[WORD_W-1] && (op_q == OP_MULXSU || op_q == OP_MULXSS))
                    ? src2_q : '0;
  assign corr_b   = (src2_q[WORD_W-1] && (op_q == OP_MULXSS)) ? src1_q : '0;
  assign fixed_hi = acc_q[ACC_W-1:WORD_W] - corr_a - corr_b;

  nios_mul_tag_pipe #(
    .DEPTH (MUL_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .adv       (mc_en),
    .in_valid  (issue_push),
    .in_shift  (cur_sel.shift),
    .out_valid (tag_out_valid),
    .out_shift (tag_out_shift),
    .busy      (tag_busy)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept, issue N products, drain the cell, fix, respond
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)     state_d = ST_ISSUE;
      ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (!tag_busy)  state_d = ST_FIX;
      ST_FIX:                   state_d = ST_DONE;
      ST_DONE:  if (rsp_ready)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; ready is forced low while reset is held
  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !reset;
    rsp_valid  = (state_q == ST_DONE);
    mc_en      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    issue_push = (state_q == ST_ISSUE);
  end

  // Datapath next values: operand capture, issue sequencing, accumulate, fix
  always_comb begin
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mc_a_d   = mc_a_q;
    mc_b_d   = mc_b_q;
    result_d = result_q;

    if (mc_en && tag_out_valid) begin
      acc_d = acc_q + pp_term;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = mul_op_e'(req_op);
          src1_d = req_src1;
          src2_d = req_src2;
          cnt_d  = 2'd0;
          acc_d  = '0;
          mc_a_d = pick_half(req_src1, first_sel.a_hi);
          mc_b_d = pick_half(req_src2, first_sel.b_hi);
        end
      end
      ST_ISSUE: begin
        if (!last_issue) begin
          cnt_d  = cnt_q + 2'd1;
          mc_a_d = pick_half(src1_q, next_sel.a_hi);
          mc_b_d = pick_half(src2_q, next_sel.b_hi);
        end
      end
      ST_FIX: begin
        acc_d[ACC_W-1:WORD_W] = fixed_hi;
        result_d = (op_q == OP_MUL) ? acc_q[WORD_W-1:0] : fixed_hi;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_MUL;
      src1_q   <= '0;
      src2_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mc_a_q   <= '0;
      mc_b_q   <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mc_a_q   <= mc_a_d;
      mc_b_q   <= mc_b_d;
      result_q <= result_d;
    end
  end

  assign mc_a       = mc_a_q;
  assign mc_b       = mc_b_q;
  assign rsp_result = result_q;

endmodule

// File: tb/tb_nios_system_nios2_gen2_0_cpu_mul_seq.sv
// Self-checking bench for the sequential multiplier. Three copies of the
// design run with cell latencies 1, 2 and 3; each is exercised in turn while
// a single negedge monitor compares every instance against a behavioural
// model built from plain 64-bit arithmetic.
module tb_nios_system_nios2_gen2_0_cpu_mul_seq;

  localparam int NINST = 3;
  localparam int NRAND = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [NINST];
  logic        req_valid  [NINST];
  logic        req_ready  [NINST];
  logic [1:0]  req_op     [NINST];
  logic [31:0] req_src1   [NINST];
  logic [31:0] req_src2   [NINST];
  logic        rsp_valid  [NINST];
  logic        rsp_ready  [NINST];
  logic [31:0] rsp_result [NINST];
  logic [15:0] mc_a       [NINST];
  logic [15:0] mc_b       [NINST];
  logic        mc_en      [NINST];
  logic [31:0] cell_pipe  [NINST][3];

  // literal expectations handed from the driver to the monitor
  bit          lit_on  [NINST];
  logic [31:0] lit_val [NINST];
  int          drv_timeouts = 0;

  // monitor-owned state and counters
  int          vectors = 0;
  int          miscompares = 0;
  int          seen_timeouts = 0;
  bit          pend    [NINST];
  int          off     [NINST];
  int          due     [NINST];
  int          en_cnt  [NINST];
  int          en_exp  [NINST];
  logic [31:0] exp_res [NINST];
  bit          lit_chk [NINST];
  logic [31:0] lit_exp [NINST];

  for (genvar g = 0; g < NINST; g++) begin : gen_inst
    nios_system_nios2_gen2_0_cpu_mul_seq #(
      .MUL_LATENCY (g + 1)
    ) dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_src1   (req_src1[g]),
      .req_src2   (req_src2[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_result (rsp_result[g]),
      .mc_a       (mc_a[g]),
      .mc_b       (mc_b[g]),
      .mc_en      (mc_en[g]),
      .mc_p       (cell_pipe[g][g])
    );
  end

  // Multiplier cell model: unsigned 16x16 with a latency set by instance,
  // advancing only while enabled and never reset
  always @(posedge clk) begin
    for (int g = 0; g < NINST; g++) begin
      if (mc_en[g]) begin
        cell_pipe[g][0] <= {16'd0, mc_a[g]} * {16'd0, mc_b[g]};
        cell_pipe[g][1] <= cell_pipe[g][0];
        cell_pipe[g][2] <= cell_pipe[g][1];
      end
    end
  end

  // Reference result: sign- or zero-extend to 64 bits and multiply
  function automatic logic [31:0] refResult(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (op == 2'b10 || op == 2'b11) ea = {{32{a[31]}}, a};
    if (op == 2'b11) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ppCount(input logic [1:0] op);
    return (op == 2'b00) ? 3 : 4;
  endfunction

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = $urandom & 32'h0000_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input int g,
                             input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s inst%0d (L=%0d) t=%0t: got 0x%0h expected 0x%0h",
               name, g, g + 1, $time, got, exp);
    end
  endtask

  // Compare process: every instance, every cycle
  always @(negedge clk) begin
    checkOutput("driver_timeout", 0, 96'(drv_timeouts), 96'(seen_timeouts));
    seen_timeouts = drv_timeouts;
    for (int g = 0; g < NINST; g++) begin
      if (reset[g]) begin
        checkOutput("reset_outputs", g,
                    96'({req_ready[g], rsp_valid[g], rsp_result[g], mc_a[g], mc_b[g], mc_en[g]}),
                    96'(0));
        pend[g] = 1'b0;
      end else if (pend[g]) begin
        off[g]++;
        if (mc_en[g]) en_cnt[g]++;
        if (off[g] < due[g]) begin
          checkOutput("busy_flags", g, 96'({rsp_valid[g], req_ready[g]}), 96'(0));
        end else begin
          checkOutput("rsp_valid_latency", g, 96'(rsp_valid[g]), 96'(1));
          checkOutput("result_vs_model", g, 96'(rsp_result[g]), 96'(exp_res[g]));
          checkOutput("ready_while_done", g, 96'(req_ready[g]), 96'(0));
          if (lit_chk[g])
            checkOutput("result_literal", g, 96'(rsp_result[g]), 96'(lit_exp[g]));
          if (rsp_valid[g] && rsp_ready[g]) begin
            checkOutput("mc_en_cycles", g, 96'(en_cnt[g]), 96'(en_exp[g]));
            pend[g] = 1'b0;
          end
        end
      end else begin
        checkOutput("idle_flags", g, 96'({req_ready[g], rsp_valid[g], mc_en[g]}), 96'(3'b100));
        if (req_valid[g] && req_ready[g]) begin
          pend[g]    = 1'b1;
          off[g]     = 0;
          en_cnt[g]  = 0;
          due[g]     = ppCount(req_op[g]) + (g + 1) + 2;
          en_exp[g]  = ppCount(req_op[g]) + (g + 1);
          exp_res[g] = refResult(req_op[g], req_src1[g], req_src2[g]);
          lit_chk[g] = lit_on[g];
          lit_exp[g] = lit_val[g];
        end
      end
    end
  end

  // One request/response; entered and left just after a rising edge so that
  // consecutive calls are back-to-back
  task automatic applyStimulus(input int g, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input int hold, input bit lit_en,
                               input logic [31:0] lit);
    int n;
    lit_on[g]    = lit_en;
    lit_val[g]   = lit;
    req_valid[g] = 1'b1;
    req_op[g]    = op;
    req_src1[g]  = a;
    req_src2[g]  = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[g] && n < 50);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    req_op[g]    = 2'($urandom);
    req_src1[g]  = $urandom;
    req_src2[g]  = $urandom;
    if (n >= 50) begin
      drv_timeouts++;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[g] && n < 60);
    if (n >= 60) begin
      drv_timeouts++;
    end
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
    rsp_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[g] = 1'b0;
  endtask

  task automatic runDirected(input int g);
    applyStimulus(g, 2'b00, 32'h0001_0003, 32'h0002_0005, 0, 1'b1, 32'h000B_000F);
    applyStimulus(g, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE);
    applyStimulus(g, 2'b11, 32'h8000_0000, 32'h8000_0000, 0, 1'b1, 32'h4000_0000);
    applyStimulus(g, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(g, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(g, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1, 32'hFFFF_FFFE);
    applyStimulus(g, 2'b00, 32'h0000_FFFF, 32'h0001_0001, 0, 1'b1, 32'hFFFF_FFFF);
  endtask

  // Kill a multiply in its second issue cycle, then check a clean restart
  task automatic runReset(input int g);
    req_valid[g] = 1'b1;
    req_op[g]    = 2'b01;
    req_src1[g]  = 32'h1234_5678;
    req_src2[g]  = 32'h9ABC_DEF0;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    @(posedge clk);
    #1;
    reset[g] = 1'b1;
    @(posedge clk);
    #1;
    reset[g] = 1'b0;
    applyStimulus(g, 2'b00, 32'h0000_0007, 32'h0000_0009, 0, 1'b1, 32'h0000_003F);
  endtask

  task automatic runRandom(input int g);
    for (int i = 0; i < NRAND; i++) begin
      if (drv_timeouts > 5) break;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(g, 2'($urandom_range(0, 3)), pickOperand(), pickOperand(),
                    $urandom_range(0, 2), 1'b0, 32'd0);
    end
  endtask

  initial begin
    for (int g = 0; g < NINST; g++) begin
      reset[g]     = 1'b1;
      req_valid[g] = 1'b0;
      req_op[g]    = 2'b00;
      req_src1[g]  = 32'd0;
      req_src2[g]  = 32'd0;
      rsp_ready[g] = 1'b0;
      lit_on[g]    = 1'b0;
      lit_val[g]   = 32'd0;
      pend[g]      = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NINST; g++) reset[g] = 1'b0;
    for (int g = 0; g < NINST; g++) begin
      $display("[TB] exercising instance with MUL_LATENCY=%0d", g + 1);
      runDirected(g);
      runReset(g);
      runRandom(g);
    end
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
